reorder_buffer: RTL
===================

# reorder_buffer

- In-order reorder buffer (ROB) between issue and the architectural register file.
- Allocates one tagged entry per issued instruction and drives the register file's speculate lane with that tag.
- Captures results from the common data bus (CDB) and retires completed entries in program order on the register file's commit lane.
- Generates the pipeline-wide flush when a mispredicted instruction retires.

## Interface
Parameters:
- ROB_IDX_LEN, 4, tag width; depth = 2**ROB_IDX_LEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alloc_valid_i  in  1  issue requests an entry.
- alloc_rd_i  in  5  destination architectural register.
- alloc_ready_o  out  1  entry available this cycle.
- alloc_tag_o  out  ROB_IDX_LEN  tag that an accepted allocation receives (the tail pointer).
- cdb_valid_i  in  1  result broadcast.
- cdb_tag_i  in  ROB_IDX_LEN  tag of the result.
- cdb_data_i  in  32  result value.
- cdb_mispredict_i  in  1  the instruction carrying this tag mispredicted.
- rs1_tag_i, rs2_tag_i  in  ROB_IDX_LEN each  operand lookup tags.
- rs1_ready_o, rs2_ready_o  out  1 each  looked-up entry has its value.
- rs1_data_o, rs2_data_o  out  32 each  looked-up value.
- speculate_o  out  1  register file speculate lane valid.
- speculate_idx_o  out  5  register index for the speculate lane.
- speculate_data_o  out  ROB_IDX_LEN  tag for the speculate lane.
- commit_o  out  1  register file commit lane valid.
- commit_idx_o  out  5  register index for the commit lane.
- commit_data_o  out  32  value for the commit lane.
- fls_o  out  1  flush pulse to the register file and the pipeline.

## Operation
- Entry fields: valid, done, mispredict, rd[4:0], data[31:0].
- Pointers: head, tail (ROB_IDX_LEN bits, wrap mod depth) and count (ROB_IDX_LEN+1 bits).
- Allocation:
  - alloc_ready_o = (count != depth) && !fls_o.
  - Accept when alloc_valid_i && alloc_ready_o: entry[tail] is set valid=1, done=0, mispredict=0, rd=alloc_rd_i; tail increments.
  - speculate_o = accept, with speculate_idx_o = alloc_rd_i and speculate_data_o = tail.
  - rd = 0 is still allocated and signalled; the register file ignores x0.
- Completion:
  - cdb_valid_i on a valid, not-done entry sets done=1, data=cdb_data_i, mispredict=cdb_mispredict_i.
  - Completion for an invalid or already-done entry is ignored.
- Retire:
  - When entry[head] is valid and done: commit_o=1, commit_idx_o=entry[head].rd, commit_data_o=entry[head].data.
  - At the edge the entry is invalidated and head increments.
  - Otherwise commit_o=0 and commit_idx_o/commit_data_o are 0.
- Flush:
  - fls_o = commit_o && entry[head].mispredict.
  - At that edge: head=tail=count=0, every valid=0; the retiring entry still commits.
  - Allocation and CDB writes in that cycle are discarded.
- Lookup (combinational):
  - rsN_ready_o = entry done, or cdb_valid_i && cdb_tag_i == rsN_tag_i (CDB bypass).
  - rsN_data_o follows the same priority, with the CDB winning.
  - If not ready, data = 0.
- Count: +1 on accept, −1 on retire, unchanged when both occur.
- Full: no allocation even if a retire occurs in the same cycle.
- Empty: commit_o=0.

## Timing
- Reset (async assert, sync release):
  - head=tail=count=0, all entries cleared.
  - Outputs: alloc_ready_o=1, alloc_tag_o=0, all others 0.
- speculate_o is asserted in the same cycle as the accepted allocation, so the register file captures the tag at the same edge.
- Earliest CDB completion: the cycle after allocation.
- Earliest commit_o: the cycle after the CDB edge.
- Minimum alloc→commit: 2 cycles.
- Sustained throughput: one allocation and one retire per cycle.
- fls_o is a single-cycle pulse, coincident with the mispredicted commit.
- First post-flush allocation receives tag 0 in the next cycle.
- Commit outputs depend only on registered state; lookup outputs are combinational in the rs*_tag_i and cdb_* inputs.

## Structure
- rob_entry_t (valid, done, mispredict, rd, data) belongs in oops_structs.
- ROB depth is derived from ROB_IDX_LEN, shared with the register file parameter.
- Single module; no sub-module.

## Test plan
- Reset then alloc rd=5 → speculate_o=1, idx=5, data=0; CDB tag0=0xDEADBEEF → next cycle commit_o=1, idx=5, data=0xDEADBEEF.
- Allocate 16 entries → alloc_ready_o=0 at count=16; complete tags 3 then 0 → commits tag0 only, tag3 waits until tags 1 and 2 complete; tail wraps to 0.
- Full buffer, head done, alloc_valid_i=1 → commit occurs, no allocation that cycle, allocation accepted the next cycle with tag 0.
- Tags 0..3 allocated, tag1 completed with mispredict, tag0 done → commit tag0, then commit tag1 with fls_o=1; next cycle count=0 and alloc_tag_o=0.
- rs1_tag_i=2 with CDB tag2=0x55 in the same cycle → rs1_ready_o=1, rs1_data_o=0x55; tag not done and no CDB → ready=0, data=0.
- Async rst asserted mid-stream with 7 entries live → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/oops_structs.sv
// Shared pipeline types and widths for the out-of-order core.
// The ROB tag width here must match the register file's tag parameter.
package oops_structs;

    localparam int XLEN            = 32;
    localparam int REG_IDX_LEN     = 5;
    localparam int ROB_IDX_LEN_DEF = 4;

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   mispredict;
        logic [REG_IDX_LEN-1:0] rd;
        logic [XLEN-1:0]        data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates tagged entries at issue, captures CDB results,
// retires in program order to the register file and raises flush on a mispredicted retire.
module reorder_buffer
    import oops_structs::*;
#(
    parameter int ROB_IDX_LEN = ROB_IDX_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid_i,
    input  logic [REG_IDX_LEN-1:0] alloc_rd_i,
    output logic                   alloc_ready_o,
    output logic [ROB_IDX_LEN-1:0] alloc_tag_o,
    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]        cdb_data_i,
    input  logic                   cdb_mispredict_i,
    input  logic [ROB_IDX_LEN-1:0] rs1_tag_i,
    input  logic [ROB_IDX_LEN-1:0] rs2_tag_i,
    output logic                   rs1_ready_o,
    output logic                   rs2_ready_o,
    output logic [XLEN-1:0]        rs1_data_o,
    output logic [XLEN-1:0]        rs2_data_o,
    output logic                   speculate_o,
    output logic [REG_IDX_LEN-1:0] speculate_idx_o,
    output logic [ROB_IDX_LEN-1:0] speculate_data_o,
    output logic                   commit_o,
    output logic [REG_IDX_LEN-1:0] commit_idx_o,
    output logic [XLEN-1:0]        commit_data_o,
    output logic                   fls_o
);

    localparam int                   DEPTH     = 2 ** ROB_IDX_LEN;
    localparam logic [ROB_IDX_LEN:0] DEPTH_CNT = (ROB_IDX_LEN + 1)'(DEPTH);

    rob_entry_t             rob [DEPTH];
    logic [ROB_IDX_LEN-1:0] head;
    logic [ROB_IDX_LEN-1:0] tail;
    logic [ROB_IDX_LEN:0]   count;

    rob_entry_t head_entry;
    logic       accept;

    // Retire and flush come purely from registered state so the register
    // file sees a clean commit lane at the start of every cycle.
    always_comb begin
        head_entry    = rob[head];
        commit_o      = head_entry.valid && head_entry.done;
        fls_o         = commit_o && head_entry.mispredict;
        commit_idx_o  = '0;
        commit_data_o = '0;
        if (commit_o) begin
            commit_idx_o  = head_entry.rd;
            commit_data_o = head_entry.data;
        end
    end

    always_comb begin
        alloc_ready_o    = (count != DEPTH_CNT) && !fls_o;
        accept           = alloc_valid_i && alloc_ready_o;
        alloc_tag_o      = tail;
        speculate_o      = accept;
        speculate_idx_o  = alloc_rd_i;
        speculate_data_o = tail;
    end

    // Operand lookup: a same-cycle CDB broadcast overrides the stored value.
    always_comb begin
        rs1_ready_o = 1'b0;
        rs1_data_o  = '0;
        rs2_ready_o = 1'b0;
        rs2_data_o  = '0;
        if (cdb_valid_i && (cdb_tag_i == rs1_tag_i)) begin
            rs1_ready_o = 1'b1;
            rs1_data_o  = cdb_data_i;
        end else if (rob[rs1_tag_i].valid && rob[rs1_tag_i].done) begin
            rs1_ready_o = 1'b1;
            rs1_data_o  = rob[rs1_tag_i].data;
        end
        if (cdb_valid_i && (cdb_tag_i == rs2_tag_i)) begin
            rs2_ready_o = 1'b1;
            rs2_data_o  = cdb_data_i;
        end else if (rob[rs2_tag_i].valid && rob[rs2_tag_i].done) begin
            rs2_ready_o = 1'b1;
            rs2_data_o  = rob[rs2_tag_i].data;
        end
    end

    // Allocation, completion and retire never hit the same entry in one cycle:
    // alloc targets an invalid slot, retire a done one, and CDB only a valid not-done one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
        end else if (fls_o) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob[i].valid <= 1'b0;
            end
        end else begin
            if (commit_o) begin
                rob[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            if (cdb_valid_i && rob[cdb_tag_i].valid && !rob[cdb_tag_i].done) begin
                rob[cdb_tag_i].done       <= 1'b1;
                rob[cdb_tag_i].data       <= cdb_data_i;
                rob[cdb_tag_i].mispredict <= cdb_mispredict_i;
            end
            if (accept) begin
                rob[tail].valid      <= 1'b1;
                rob[tail].done       <= 1'b0;
                rob[tail].mispredict <= 1'b0;
                rob[tail].rd         <= alloc_rd_i;
                tail                 <= tail + 1'b1;
            end
            case ({accept, commit_o})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
